// File: rtl/serial_pkg.sv
// +----------------------------------------------------------------------+
// | serial_pkg: shared types/constants for the single-wire serial link    |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package serial_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    DATA = 3'd2,
    PAR  = 3'd3,
    GAP  = 3'd4
  } tx_state_t;

  // Sync pattern shared with the receive-side detector.
  localparam logic [2:0] SYNC_PATTERN = 3'b101;

endpackage

`default_nettype wire

// File: rtl/frame_tx_if.sv
// +----------------------------------------------------------------------+
// | frame_tx_if: valid/ready payload handshake into the frame transmitter |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

interface frame_tx_if #(
  parameter int DATA_W = 8
) ();

  logic [DATA_W-1:0] data_in;
  logic              valid;
  logic              ready;

  modport master (output data_in, output valid, input ready);
  modport slave  (input data_in, input valid, output ready);

endinterface

`default_nettype wire

// File: rtl/frame_tx.sv
// +----------------------------------------------------------------------+
// | frame_tx: serialises preamble, MSB-first payload, even parity, guard 0 |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module frame_tx
  import serial_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                PRE_W    = 3,
  parameter logic [PRE_W-1:0]  PREAMBLE = PRE_W'(SYNC_PATTERN)
) (
  input  logic       clk,
  input  logic       rst_n,
  frame_tx_if.slave  tx,
  output logic       dout,
  output logic       busy,
  output logic       frame_end
);

  localparam int MAX_W = (DATA_W > PRE_W) ? DATA_W : PRE_W;
  localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  localparam logic [CNT_W-1:0] C_CNT_PRE  = CNT_W'(PRE_W - 1);
  localparam logic [CNT_W-1:0] C_CNT_DATA = CNT_W'(DATA_W - 1);

  tx_state_t         state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] sh_q;
  logic              par_q;
  logic              dout_q;

  logic [CNT_W-1:0]  w_cnt_dec;
  logic [PRE_W-1:0]  w_pre_shift;
  logic [DATA_W-1:0] w_sh_next;

  assign w_cnt_dec   = cnt_q - 1'b1;
  assign w_pre_shift = PREAMBLE >> w_cnt_dec;
  assign w_sh_next   = {sh_q[DATA_W-2:0], 1'b0};

  // dout is registered one step ahead: each edge loads the bit that the
  // state being entered must present, so the line has no input path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      dout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tx.valid) begin
            sh_q    <= tx.data_in;
            par_q   <= ^tx.data_in;
            cnt_q   <= C_CNT_PRE;
            dout_q  <= PREAMBLE[PRE_W-1];
            state_q <= PRE;
          end else begin
            dout_q  <= 1'b0;
          end
        end
        PRE: begin
          if (cnt_q == '0) begin
            cnt_q   <= C_CNT_DATA;
            dout_q  <= sh_q[DATA_W-1];
            sh_q    <= w_sh_next;
            state_q <= DATA;
          end else begin
            cnt_q   <= w_cnt_dec;
            dout_q  <= w_pre_shift[0];
          end
        end
        DATA: begin
          if (cnt_q == '0) begin
            dout_q  <= par_q;
            state_q <= PAR;
          end else begin
            cnt_q   <= w_cnt_dec;
            dout_q  <= sh_q[DATA_W-1];
            sh_q    <= w_sh_next;
          end
        end
        PAR: begin
          dout_q  <= 1'b0;
          state_q <= GAP;
        end
        GAP: begin
          dout_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          dout_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx.ready  = (state_q == IDLE);
  assign dout      = dout_q;
  assign busy      = (state_q != IDLE);
  assign frame_end = (state_q == GAP);

endmodule

`default_nettype wire

// File: tb/tb_frame_tx.sv
// +----------------------------------------------------------------------+
// | tb_frame_tx: directed vector bench for frame_tx                       |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_frame_tx;

  typedef struct {
    logic [7:0]  data;
    logic [12:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic dout, busy, frame_end;

  always #5 clk = ~clk;

  frame_tx_if #(.DATA_W(8)) tx_if ();

  frame_tx #(
    .DATA_W   (8),
    .PRE_W    (3),
    .PREAMBLE (3'b101)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx        (tx_if),
    .dout      (dout),
    .busy      (busy),
    .frame_end (frame_end)
  );

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   hs_q[$];
  logic dlog [0:4095];
  logic blog [0:4095];
  logic flog [0:4095];
  logic rlog [0:4095];
  vec_t vecs [6];

  // Handshake at the edge ending cycle cyc; outputs of cycle cyc logged at negedge.
  always @(posedge clk) begin
    if (rst_n === 1'b1 && tx_if.valid === 1'b1 && tx_if.ready === 1'b1)
      hs_q.push_back(cyc);
    cyc++;
  end

  always @(negedge clk) begin
    if (cyc < 4096) begin
      dlog[cyc] = dout;
      blog[cyc] = busy;
      flog[cyc] = frame_end;
      rlog[cyc] = tx_if.ready;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_hs(input int n0, output int k);
    for (int i = 0; i < 40 && hs_q.size() <= n0; i++) @(negedge clk);
    if (hs_q.size() > n0) begin
      k = hs_q[n0];
    end else begin
      chk("hs_timeout", 32'd0, 32'd1);
      k = 0;
    end
  endtask

  task automatic check_frame(input int k, input logic [12:0] exp, input string nm);
    logic [12:0] d, b, f, r;
    for (int i = 0; i < 13; i++) begin
      d[12-i] = dlog[k+1+i];
      b[12-i] = blog[k+1+i];
      f[12-i] = flog[k+1+i];
      r[12-i] = rlog[k+1+i];
    end
    chk({nm, "_dout"},      32'(d), 32'(exp));
    chk({nm, "_busy"},      32'(b), 32'h1FFF);
    chk({nm, "_frame_end"}, 32'(f), 32'h0001);
    chk({nm, "_ready"},     32'(r), 32'h0000);
    chk({nm, "_after"},     32'({rlog[k+14], blog[k+14], dlog[k+14]}), 32'b100);
  endtask

  task automatic run_frame(input logic [7:0] data, input logic [12:0] exp, input string nm);
    int n0, k;
    n0 = hs_q.size();
    tx_if.valid   = 1'b1;
    tx_if.data_in = data;
    wait_hs(n0, k);
    tx_if.valid   = 1'b0;
    tx_if.data_in = ~data;
    repeat (14) @(negedge clk);
    #1;
    check_frame(k, exp, nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, k, k1, k2;

    vecs[0] = '{8'hA5, 13'b101_10100101_0_0};
    vecs[1] = '{8'h01, 13'b101_00000001_1_0};
    vecs[2] = '{8'h80, 13'b101_10000000_1_0};
    vecs[3] = '{8'h7E, 13'b101_01111110_0_0};
    vecs[4] = '{8'hC3, 13'b101_11000011_0_0};
    vecs[5] = '{8'h00, 13'b101_00000000_0_0};

    rst_n         = 1'b0;
    tx_if.valid   = 1'b0;
    tx_if.data_in = 8'h00;
    @(negedge clk); #1;
    chk("in_reset", 32'({tx_if.ready, dout, busy, frame_end}), 32'b1000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk($sformatf("idle%0d", i), 32'({tx_if.ready, dout, busy, frame_end}), 32'b1000);
    end

    for (int i = 0; i < 6; i++)
      run_frame(vecs[i].data, vecs[i].exp, $sformatf("vec%0d_%02h", i, vecs[i].data));

    // valid held high across two frames
    @(negedge clk);
    n0 = hs_q.size();
    tx_if.valid   = 1'b1;
    tx_if.data_in = 8'hFF;
    wait_hs(n0, k1);
    tx_if.data_in = 8'h00;
    wait_hs(n0 + 1, k2);
    tx_if.valid = 1'b0;
    repeat (14) @(negedge clk);
    #1;
    chk("b2b_spacing", 32'(k2 - k1), 32'd14);
    check_frame(k1, 13'b101_11111111_0_0, "b2b_ff");
    check_frame(k2, 13'b101_00000000_0_0, "b2b_00");

    // word offered while busy is ignored
    n0 = hs_q.size();
    tx_if.valid   = 1'b1;
    tx_if.data_in = 8'hA5;
    wait_hs(n0, k);
    tx_if.valid   = 1'b0;
    tx_if.data_in = 8'h00;
    repeat (5) @(negedge clk);
    tx_if.valid   = 1'b1;
    tx_if.data_in = 8'h3C;
    repeat (3) @(negedge clk);
    tx_if.valid   = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check_frame(k, 13'b101_10100101_0_0, "busy_3c");
    chk("busy_3c_hs_count", 32'(hs_q.size()), 32'(n0 + 1));

    // asynchronous abort during the 5th payload bit
    n0 = hs_q.size();
    tx_if.valid   = 1'b1;
    tx_if.data_in = 8'hFF;
    wait_hs(n0, k);
    tx_if.valid   = 1'b0;
    repeat (7) @(negedge clk);
    #1;
    chk("pre_abort", 32'({tx_if.ready, dout, busy, frame_end}), 32'b0110);
    #1 rst_n = 1'b0;
    #1;
    chk("abort", 32'({tx_if.ready, dout, busy, frame_end}), 32'b1000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("post_abort_idle", 32'({tx_if.ready, dout, busy, frame_end}), 32'b1000);
    run_frame(8'hA5, 13'b101_10100101_0_0, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
